// File: rtl/fpu_pkg.sv
// Shared types and helpers for the FPU square-root issue/capture stage:
// FSM states, RISC-V and core rounding encodings, status-to-fflags mapping.
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sqrt_state_e;

  // RISC-V rm field encodings
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  // Rounding encodings understood by the sqrt core
  localparam logic [2:0] DW_RND_RNE = 3'd0;
  localparam logic [2:0] DW_RND_RTZ = 3'd1;
  localparam logic [2:0] DW_RND_UP  = 3'd2;
  localparam logic [2:0] DW_RND_DN  = 3'd3;
  localparam logic [2:0] DW_RND_RMM = 3'd4;

  typedef struct packed {
    logic       legal;
    logic [2:0] rnd;
  } rnd_res_t;

  // Sqrt results are non-negative, so RMM maps onto the core's ties-away mode.
  function automatic rnd_res_t rm_to_dw_rnd(input logic [2:0] eff);
    rnd_res_t res;
    res = '{legal: 1'b1, rnd: DW_RND_RNE};
    case (eff)
      RM_RNE:  res.rnd = DW_RND_RNE;
      RM_RTZ:  res.rnd = DW_RND_RTZ;
      RM_RDN:  res.rnd = DW_RND_DN;
      RM_RUP:  res.rnd = DW_RND_UP;
      RM_RMM:  res.rnd = DW_RND_RMM;
      default: res.legal = 1'b0;
    endcase
    return res;
  endfunction

  // {NV,DZ,OF,UF,NX}; UF is only raised when the result is also inexact.
  function automatic logic [4:0] dw_status_to_fflags(input logic [7:0] status);
    return {status[2], 1'b0, status[4], status[3] & status[5], status[5]};
  endfunction

endpackage

// File: rtl/fpu_sqrt_ctrl.sv
// Issue/capture wrapper around the combinational sqrt core: registers the
// operand for SQRT_CYCLES cycles, captures result/status, returns to writeback.
module fpu_sqrt_ctrl
  import fpu_pkg::*;
#(
  parameter int SIG_W       = 23,
  parameter int EXP_W       = 8,
  parameter int SQRT_CYCLES = 3,
  parameter int TAG_W       = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SIG_W+EXP_W:0]   in_a,
  input  logic [2:0]             in_rm,
  input  logic [2:0]             in_frm,
  input  logic [TAG_W-1:0]       in_tag,
  output logic [SIG_W+EXP_W:0]   sq_a,
  output logic [2:0]             sq_rnd,
  input  logic [SIG_W+EXP_W:0]   sq_z,
  input  logic [7:0]             sq_status,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIG_W+EXP_W:0]   out_z,
  output logic [4:0]             out_fflags,
  output logic                   out_illegal,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int CNT_W = 4;

  sqrt_state_e state, state_nx;
  logic [CNT_W-1:0] count;
  logic [2:0]       eff_rm;
  rnd_res_t         rnd_res;
  logic             issue, capture, handshake;

  // flush masks both handshakes so neither side sees a transfer that is discarded
  assign in_ready  = (state == IDLE) && !flush;
  assign out_valid = (state == DONE) && !flush;
  assign issue     = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign capture   = (state == BUSY) && (count == '0) && !flush;
  assign eff_rm    = (in_rm == RM_DYN) ? in_frm : in_rm;
  assign rnd_res   = rm_to_dw_rnd(eff_rm);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (issue) state_nx = rnd_res.legal ? BUSY : DONE;
      BUSY: if (count == '0) state_nx = DONE;
      DONE: if (handshake) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      sq_a        <= '0;
      sq_rnd      <= '0;
      out_z       <= '0;
      out_fflags  <= '0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
    end else if (flush) begin
      out_illegal <= 1'b0;
    end else begin
      if (issue) begin
        out_tag <= in_tag;
        if (rnd_res.legal) begin
          sq_a   <= in_a;
          sq_rnd <= rnd_res.rnd;
          count  <= CNT_W'(SQRT_CYCLES - 1);
        end else begin
          out_illegal <= 1'b1;
          out_z       <= '0;
          out_fflags  <= '0;
        end
      end
      if (state == BUSY && count != '0) count <= count - 1'b1;
      if (capture) begin
        out_z      <= sq_z;
        out_fflags <= dw_status_to_fflags(sq_status);
      end
      if (handshake) out_illegal <= 1'b0;
    end
  end

endmodule
